// File: rtl/camera_config_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_pkg
// Description : Shared constants, config-entry field layout and sequencer
//               state encoding for the camera configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // Config ROM entry layout: {addr[7:0], value[7:0], rw}
    localparam int          c_ENTRY_W      = 17;
    localparam int          c_ADDR_MSB     = 16;
    localparam int          c_ADDR_LSB     = 9;
    localparam int          c_WDATA_MSB    = 8;
    localparam int          c_WDATA_LSB    = 1;
    localparam int          c_RW_BIT       = 0;

    // Special table entries (both carry rw=1)
    localparam logic [15:0] c_END_MARKER   = 16'hFFFF;
    localparam logic [15:0] c_DELAY_MARKER = 16'hF0F0;

    localparam int          c_INDEX_W      = 6;
    localparam logic [5:0]  c_LAST_INDEX   = 6'd63;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_ISSUE  = 4'd3,
        ST_WAIT   = 4'd4,
        ST_DELAY  = 4'd5,
        ST_NEXT   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    // True when the entry is the given 16-bit marker with rw=1
    function automatic logic is_marker(input logic [c_ENTRY_W-1:0] entry,
                                       input logic [15:0]          marker);
        return entry == {marker, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/camera_config_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : camera_config_seq_if
// Description : Request/completion bus between the configuration sequencer
//               (master) and the SCCB master engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface camera_config_seq_if;
    logic       sccb_req_o;
    logic [7:0] sccb_addr_o;
    logic [7:0] sccb_wdata_o;
    logic       sccb_rw_o;
    logic       sccb_done_i;
    logic       sccb_nack_i;
    logic [7:0] sccb_rdata_i;

    modport master (
        output sccb_req_o, sccb_addr_o, sccb_wdata_o, sccb_rw_o,
        input  sccb_done_i, sccb_nack_i, sccb_rdata_i
    );

    modport slave (
        input  sccb_req_o, sccb_addr_o, sccb_wdata_o, sccb_rw_o,
        output sccb_done_i, sccb_nack_i, sccb_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/cfg_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_delay_timer
// Description : Loadable down-counter; expire_o is high on the last of
//               DELAY_CYCLES cycles following a load.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_delay_timer #(
    parameter int DELAY_CYCLES = 1200000
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic load_i,
    output logic      expire_o
);
    // A zero or negative length still waits one cycle
    localparam int c_CYCLES = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
    localparam int c_CNT_W  = $clog2(c_CYCLES + 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_active;

    // Count down from the load value; drop out of the active phase on expiry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (load_i) begin
            r_count  <= c_CNT_W'(c_CYCLES);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_count <= r_count - c_CNT_W'(1);
            if (r_count == c_CNT_W'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign expire_o = r_active && (r_count == c_CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/camera_config_seq.sv
`default_nettype none
// ============================================================================
// Module      : camera_config_seq
// Description : Walks an external config ROM and replays each entry as an
//               SCCB read/write, with delay markers, NACK retry and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_config_seq
    import camera_pkg::*;
#(
    parameter int DELAY_CYCLES = 1200000,
    parameter int MAX_RETRY    = 3
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 start_i,
    output logic [c_INDEX_W-1:0]      index_o,
    input  wire logic [c_ENTRY_W-1:0] rom_data_i,
    camera_config_seq_if.master       sccb,
    output logic                      rd_valid_o,
    output logic [7:0]                rd_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);
    // Retry counter must reach MAX_RETRY+1 without wrapping
    localparam int                  c_RETRY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_ENTRY_W-1:0]   r_entry;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_inc;
    logic                   w_timer_load;
    logic                   w_timer_expire;
    logic                   w_ack;
    logic                   w_nack;

    assign w_ack       = (r_state == ST_WAIT) && sccb.sccb_done_i && !sccb.sccb_nack_i;
    assign w_nack      = (r_state == ST_WAIT) && sccb.sccb_done_i &&  sccb.sccb_nack_i;
    assign w_retry_inc = r_retry + c_RETRY_W'(1);

    cfg_delay_timer #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_timer_load),
        .expire_o (w_timer_expire)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and delay-timer load
    always_comb begin
        w_next       = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) w_next = ST_FETCH;
            end
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                if (is_marker(r_entry, c_END_MARKER)) begin
                    w_next = ST_DONE;
                end else if (is_marker(r_entry, c_DELAY_MARKER)) begin
                    w_next       = ST_DELAY;
                    w_timer_load = 1'b1;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE:  w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_ack) begin
                    w_next = ST_NEXT;
                end else if (w_nack) begin
                    w_next = (w_retry_inc <= c_MAX_RETRY) ? ST_ISSUE : ST_ERROR;
                end
            end
            ST_DELAY: begin
                if (w_timer_expire) w_next = ST_NEXT;
            end
            ST_NEXT:   w_next = (index_o == c_LAST_INDEX) ? ST_DONE : ST_FETCH;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath: table index, latched entry, SCCB request and read capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            index_o           <= '0;
            r_entry           <= '0;
            r_retry           <= '0;
            sccb.sccb_req_o   <= 1'b0;
            sccb.sccb_addr_o  <= '0;
            sccb.sccb_wdata_o <= '0;
            sccb.sccb_rw_o    <= 1'b0;
            rd_valid_o        <= 1'b0;
            rd_data_o         <= '0;
        end else begin
            rd_valid_o <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        index_o <= '0;
                        r_retry <= '0;
                    end
                end
                ST_FETCH: r_entry <= rom_data_i;
                ST_ISSUE: begin
                    sccb.sccb_req_o   <= 1'b1;
                    sccb.sccb_addr_o  <= r_entry[c_ADDR_MSB:c_ADDR_LSB];
                    sccb.sccb_wdata_o <= r_entry[c_WDATA_MSB:c_WDATA_LSB];
                    sccb.sccb_rw_o    <= r_entry[c_RW_BIT];
                end
                ST_WAIT: begin
                    if (sccb.sccb_done_i) begin
                        // Dropping req on NACK too guarantees a low cycle before a retry
                        sccb.sccb_req_o <= 1'b0;
                        if (sccb.sccb_nack_i) begin
                            r_retry <= w_retry_inc;
                        end else if (!sccb.sccb_rw_o) begin
                            rd_valid_o <= 1'b1;
                            rd_data_o  <= sccb.sccb_rdata_i;
                        end
                    end
                end
                ST_NEXT: begin
                    r_retry <= '0;
                    if (index_o != c_LAST_INDEX) begin
                        index_o <= index_o + c_INDEX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
    assign done_o = (r_state == ST_DONE);
    assign err_o  = (r_state == ST_ERROR);
endmodule
`default_nettype wire

// File: tb/tb_camera_config_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_config_seq
// Description : Self-checking bench: table-walk model predicts every request,
//               read pulse and status per cycle; directed tables exercise it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_config_seq;
    localparam int D   = 10;
    localparam int MR  = 3;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  index;
    logic [16:0] rom_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy, done, err;
    logic [16:0] rom [64];

    camera_config_seq_if bus();

    camera_config_seq #(.DELAY_CYCLES(D), .MAX_RETRY(MR)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .index_o(index),
        .rom_data_i(rom_data), .sccb(bus), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[index];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nfail = 0;
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // SCCB slave: done LAT cycles after each rising req; first nack_first_n attempts NACKed
    int         nack_first_n = 0;
    logic [7:0] rdata_val = 8'h76;
    initial begin : slave
        int cnt; bit pend; bit prev; int att;
        cnt = 0; pend = 0; prev = 0; att = 0;
        bus.sccb_done_i = 1'b0; bus.sccb_nack_i = 1'b0; bus.sccb_rdata_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.sccb_done_i = 1'b0;
            bus.sccb_nack_i = 1'b0;
            if (rst) begin
                pend = 0; prev = 0;
            end else begin
                if (!busy) att = 0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 0;
                        bus.sccb_done_i  = 1'b1;
                        bus.sccb_nack_i  = (att < nack_first_n);
                        bus.sccb_rdata_i = rdata_val;
                        att++;
                    end
                end else if (bus.sccb_req_o && !prev) begin
                    pend = 1; cnt = LAT;
                end
                prev = bus.sccb_req_o;
            end
        end
    end

    // Model: walk the table, derive request windows, read pulses and end of pass
    typedef struct { int rise; logic [7:0] addr; logic [7:0] wdata; logic rw; } txn_t;
    txn_t       m_txn[$];
    int         m_rd_cyc[$];
    logic [7:0] m_rd_dat[$];
    int         m_start, m_end;
    bit         m_end_err;
    logic [5:0] m_end_idx;
    bit         m_prev_done = 0, m_prev_err = 0;
    bit         m_active = 0;

    task automatic build_model(int s);
        int t, idx, att, nacks, r, nxt;
        bit fin, ok;
        logic [16:0] e;
        m_txn.delete(); m_rd_cyc.delete(); m_rd_dat.delete();
        m_start = s; t = s + 1; idx = 0; att = 0; fin = 0;
        while (!fin) begin
            e = rom[idx];
            if (e == {16'hFFFF, 1'b1}) begin
                m_end = t + 2; m_end_err = 0; m_end_idx = idx[5:0]; fin = 1;
            end else begin
                if (e == {16'hF0F0, 1'b1}) begin
                    nxt = t + 2 + D;
                end else begin
                    r = t + 3; nacks = 0; ok = 0;
                    while (!ok && !fin) begin
                        m_txn.push_back('{r, e[16:9], e[8:1], e[0]});
                        if (att < nack_first_n) begin
                            att++; nacks++;
                            if (nacks > MR) begin
                                m_end = r + LAT + 1; m_end_err = 1; m_end_idx = idx[5:0]; fin = 1;
                            end else begin
                                r = r + LAT + 2;
                            end
                        end else begin
                            att++; ok = 1;
                        end
                    end
                    if (ok && !e[0]) begin
                        m_rd_cyc.push_back(r + LAT + 1);
                        m_rd_dat.push_back(rdata_val);
                    end
                    nxt = r + LAT + 1;
                end
                if (!fin) begin
                    if (idx == 63) begin
                        m_end = nxt + 1; m_end_err = 0; m_end_idx = 6'd63; fin = 1;
                    end else begin
                        idx++; t = nxt + 1;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin : cmp
        logic       er, ev;
        logic [2:0] est;
        logic [16:0] et;
        logic [7:0] ed;
        if (m_active && !rst) begin
            er = 0; ev = 0; et = '0; ed = '0;
            foreach (m_txn[i])
                if (cyc >= m_txn[i].rise && cyc <= m_txn[i].rise + LAT) begin
                    er = 1; et = {m_txn[i].addr, m_txn[i].wdata, m_txn[i].rw};
                end
            foreach (m_rd_cyc[i])
                if (cyc == m_rd_cyc[i]) begin ev = 1; ed = m_rd_dat[i]; end
            if (cyc <= m_start)   est = {1'b0, m_prev_done, m_prev_err};
            else if (cyc < m_end) est = 3'b100;
            else                  est = {1'b0, !m_end_err, m_end_err};
            check("busy/done/err/req/rd_valid", {busy, done, err, bus.sccb_req_o, rd_valid}, {est, er, ev});
            if (er) check("addr/wdata/rw", {bus.sccb_addr_o, bus.sccb_wdata_o, bus.sccb_rw_o}, et);
            if (ev) check("rd_data", rd_data, ed);
        end
    end

    // Observed request and read-pulse counts
    int obs_req = 0, obs_rd = 0;
    logic prev_req = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sccb_req_o && !prev_req) obs_req++;
            if (rd_valid) obs_rd++;
            prev_req = bus.sccb_req_o;
        end else begin
            prev_req = 0;
        end
    end

    bit st_done = 0, st_err = 0;
    int base_req, base_rd;

    task automatic begin_pass();
        @(posedge clk); #1;
        m_prev_done = st_done; m_prev_err = st_err;
        base_req = obs_req; base_rd = obs_rd;
        build_model(cyc);
        m_active = 1;
        start = 1'b1;
    endtask

    task automatic finish_pass(string tag, int poke);
        while (cyc < m_end + 6) begin
            @(posedge clk); #1;
            start = (poke > 0 && cyc == m_start + poke);
        end
        start = 1'b0;
        check({tag, " requests"}, obs_req - base_req, m_txn.size());
        check({tag, " read pulses"}, obs_rd - base_rd, m_rd_cyc.size());
        check({tag, " index"}, index, m_end_idx);
        check({tag, " done/err"}, {done, err}, {!m_end_err, m_end_err});
        st_done = !m_end_err; st_err = m_end_err;
    endtask

    task automatic fill_end();
        for (int i = 0; i < 64; i++) rom[i] = {16'hFFFF, 1'b1};
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " outputs"},
              {index, bus.sccb_req_o, bus.sccb_addr_o, bus.sccb_wdata_o, bus.sccb_rw_o,
               rd_valid, rd_data, busy, done, err}, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        fill_end();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;

        // Write, delay marker, write, end
        rom[0] = {16'h1280, 1'b1}; rom[1] = {16'hF0F0, 1'b1};
        rom[2] = {16'h1204, 1'b1}; rom[3] = {16'hFFFF, 1'b1};
        begin_pass();
        check("pin first req latency", m_txn[0].rise - m_start, 4);
        check("pin req-to-req gap", m_txn[1].rise - m_txn[0].rise, 20);
        check("pin delay table requests", m_txn.size(), 2);
        check("pin second write", {m_txn[1].addr, m_txn[1].wdata}, 16'h1204);
        finish_pass("delay table", 0);

        // Second pass after DONE, with a start pulse while busy
        begin_pass();
        finish_pass("repeat pass", 8);

        // Read entry
        fill_end();
        rom[0] = {16'h0A00, 1'b0};
        begin_pass();
        check("pin read pulse count", m_rd_dat.size(), 1);
        check("pin read pulse cycle", m_rd_cyc[0] - m_start, 7);
        finish_pass("read", 0);

        // Three NACKs then ACK
        rom[0] = {16'h3456, 1'b1};
        nack_first_n = 3;
        begin_pass();
        check("pin retry requests", m_txn.size(), 4);
        finish_pass("retry ok", 0);

        // NACK on every attempt -> abort
        nack_first_n = 4;
        begin_pass();
        check("pin abort requests", m_txn.size(), 4);
        check("pin abort flag", m_end_err, 1);
        finish_pass("abort", 0);
        nack_first_n = 0;

        // Full 64-entry table, no end marker
        for (int i = 0; i < 64; i++) rom[i] = {i[7:0], i[7:0] ^ 8'h5A, 1'b1};
        begin_pass();
        check("pin full table requests", m_txn.size(), 64);
        check("pin full table length", m_end - m_start, 449);
        finish_pass("full table", 0);

        // Reset in the middle of a transaction
        fill_end();
        rom[0] = {16'h1280, 1'b1}; rom[1] = {16'hF0F0, 1'b1};
        rom[2] = {16'h1204, 1'b1}; rom[3] = {16'hFFFF, 1'b1};
        begin_pass();
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!bus.sccb_req_o && k < 50) begin @(posedge clk); #1; k++; end
        check("reached wait before reset", bus.sccb_req_o, 1'b1);
        m_active = 0;
        @(negedge clk); #2 rst = 1'b1;
        #1 check_reset_outputs("async reset");
        @(posedge clk); #1 rst = 1'b0;
        st_done = 0; st_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no request after reset", {bus.sccb_req_o, busy}, 2'b00);
        end
        begin_pass();
        finish_pass("restart after reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire
